// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU, RISC-V semantics).
// One quotient bit per clock. The start/busy/done handshake stalls the pipeline while busy.
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst   - synchronous, active-high reset
//   start - request; only sampled in IDLE
//   op    - 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   a, b  - dividend and divisor; captured on an accepted start
//   busy  - high in CALC and DONE
//   done  - one-cycle pulse; y is valid in that cycle
//   y     - quotient or remainder; held until the next result loads
module seq_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] y
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic            rem_sel_q, rem_sel_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] y_q, y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Iteration datapath signals
  logic [XLEN:0]   rem_ext;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_iter;
  logic [XLEN-1:0] quo_iter;
  logic            is_signed;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  // One restoring step. The remainder is widened by one bit so that a remainder with
  // its MSB set (possible for unsigned divisors >= 2^(XLEN-1)) is not lost on the shift.
  always_comb begin
    rem_ext  = {rem_q, dvd_q[XLEN-1]};
    diff     = rem_ext - {1'b0, dsr_q};
    q_bit    = ~diff[XLEN];
    rem_iter = q_bit ? diff[XLEN-1:0] : rem_ext[XLEN-1:0];
    quo_iter = {quo_q[XLEN-2:0], q_bit};
  end

  // Operand magnitudes for signed ops; unsigned ops pass through unchanged
  always_comb begin
    is_signed = ~op[0];
    abs_a     = (is_signed && a[XLEN-1]) ? (-a) : a;
    abs_b     = (is_signed && b[XLEN-1]) ? (-b) : b;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    y_d       = y_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_sel_d = op[1];
          neg_q_d   = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
          neg_r_d   = is_signed & a[XLEN-1];
          dvd_d     = abs_a;
          dsr_d     = abs_b;
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = CW'(XLEN);
          if (b == '0) begin
            // Divide by zero: quotient all-ones, remainder is the raw dividend
            y_d     = op[1] ? a : '1;
            state_d = S_DONE;
          end else if (is_signed && (a == MIN_NEG) && (b == '1)) begin
            // Signed overflow: quotient wraps to the dividend, remainder zero
            y_d     = op[1] ? '0 : a;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_iter;
        quo_d = quo_iter;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last iteration: fold the sign fix-up into the result register
          if (rem_sel_q) y_d = neg_r_q ? (-rem_iter) : rem_iter;
          else           y_d = neg_q_q ? (-quo_iter) : quo_iter;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule
